mult_acc_unit: RTL and testbench
================================

MULT_ACC_UNIT -- requirements
Module: mult_acc_unit

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the operand width in bits.
REQ-002 The block SHALL have parameter LEN_W, default 5, giving the width of the pair-count field.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the reset: synchronous, active-low.
REQ-005 Port start, input, 1 bit, SHALL request a new accumulation run.
REQ-006 Port len, input, LEN_W bits, SHALL give the number of operand pairs in the run and SHALL be sampled when start is accepted.
REQ-007 Port a_in, input, N bits, SHALL carry the unsigned multiplicand.
REQ-008 Port b_in, input, N bits, SHALL carry the unsigned multiplier.
REQ-009 Port in_valid, input, 1 bit, SHALL indicate that a_in and b_in are valid.
REQ-010 Port in_ready, output, 1 bit, SHALL indicate that the block accepts an operand pair this cycle.
REQ-011 Port acc_out, output, 2N+LEN_W bits (21), SHALL carry the registered accumulator.
REQ-012 Port done, output, 1 bit, SHALL indicate that acc_out holds the final result.
REQ-013 Port ack, input, 1 bit, SHALL acknowledge consumption of the result.
REQ-014 Port busy, output, 1 bit, SHALL be high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 IDLE SHALL drive in_ready=0, done=0 and busy=0, and SHALL hold acc_out at its last value.
REQ-017 In IDLE, start=1 SHALL clear the accumulator to 0, load the remaining-count register with len, and go to RUN if len is nonzero or to DONE if len=0.
REQ-018 RUN SHALL drive in_ready=1 combinationally.
REQ-019 A pair is accepted in a cycle where in_valid=1 and in_ready=1.
REQ-020 On acceptance, the product a_in*b_in SHALL be formed by an N x N unsigned array multiplier, zero-extended to 2N+LEN_W bits, and added into the accumulator at that clock edge (one-cycle latency to acc_out).
REQ-021 On acceptance, remaining SHALL decrement by 1.
REQ-022 Acceptance while remaining=1 SHALL transition RUN->DONE.
REQ-023 A cycle in RUN with in_valid=0 SHALL leave the accumulator and remaining unchanged, with no timeout.
REQ-024 DONE SHALL drive done=1 and in_ready=0, and SHALL hold acc_out stable.
REQ-025 In DONE, ack=1 SHALL transition DONE->IDLE; done SHALL deassert on the following cycle.
REQ-026 start SHALL be ignored outside IDLE, including when start and ack are both high in DONE; only the ack takes effect in that case.
REQ-027 ack SHALL be ignored outside DONE.
REQ-028 Accumulator width SHALL be sized so no overflow occurs for up to 2^LEN_W-1 pairs of maximum operands; no saturation or overflow flag is required.

Reset
REQ-029 rst=0 at a clock edge SHALL force IDLE, accumulator=0, remaining=0, in_ready=0, done=0 and busy=0, overriding all other inputs.
REQ-030 Reset asserted mid-RUN or in DONE SHALL abort the run with no result reported; the next run SHALL require a fresh start.

Verification
REQ-031 The bench SHALL cover the basic run: start with len=3, then pairs (2,3), (4,5), (255,255) on consecutive cycles -> done=1 one cycle after the third acceptance and acc_out=65051.
REQ-032 The bench SHALL cover the empty run: start with len=0 -> DONE on the next cycle with acc_out=0 and in_ready never asserted.
REQ-033 The bench SHALL cover the maximum run: len=31 with all pairs (255,255) -> acc_out=2015775, no wrap.
REQ-034 The bench SHALL cover stalls: len=2 with in_valid low for 4 cycles between the pairs (10,10) and (1,1) -> acc_out=101, busy high throughout, done only after the second pair.
REQ-035 The bench SHALL cover reset during RUN: rst=0 after one of two pairs is accepted -> next cycle in IDLE with acc_out=0 and busy=0; a new run then gives a correct fresh result.
REQ-036 The bench SHALL cover DONE handshake corners: start and ack both high in DONE -> IDLE with no new run started; ack held low for 10 cycles -> done and acc_out held stable for all 10.

Source files
------------

// File: rtl/mult_acc_unit.sv
// Multiply-accumulate unit: sums len unsigned a*b products into a registered
// accumulator under a start / valid-ready / done-ack handshake.
module mult_acc_unit #(
  parameter int N     = 8,
  parameter int LEN_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LEN_W-1:0]       len,
  input  logic [N-1:0]           a_in,
  input  logic [N-1:0]           b_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [2*N+LEN_W-1:0]   acc_out,
  output logic                   done,
  input  logic                   ack,
  output logic                   busy
);

  localparam int ACC_W = 2*N + LEN_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Unsigned array multiplier: each row ripple-adds one partial product into
  // the running high part; the row's low bit retires as a product bit.
  function automatic logic [2*N-1:0] array_mult(input logic [N-1:0] a,
                                                input logic [N-1:0] b);
    logic [N-1:0]   pp;
    logic [N-1:0]   upper;
    logic [N-1:0]   sum;
    logic           c;
    logic [2*N-1:0] p;
    p     = '0;
    pp    = a & {N{b[0]}};
    p[0]  = pp[0];
    upper = {1'b0, pp[N-1:1]};
    for (int i = 1; i < N; i++) begin
      pp = a & {N{b[i]}};
      c  = 1'b0;
      for (int j = 0; j < N; j++) begin
        sum[j] = upper[j] ^ pp[j] ^ c;
        c      = (upper[j] & pp[j]) | (c & (upper[j] ^ pp[j]));
      end
      p[i]  = sum[0];
      upper = {c, sum[N-1:1]};
    end
    p[2*N-1:N] = upper;
    return p;
  endfunction

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               done_q, busy_q;
  logic [2*N-1:0]     prod_p0;
  logic               vld_p0;

  // Stage p0: product of the pair presented this cycle
  assign prod_p0  = array_mult(a_in, b_in);
  assign in_ready = (state_q == RUN);
  assign vld_p0   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          rem_d   = len;
          state_d = (len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (vld_p0) begin
          acc_d = acc_q + {{LEN_W{1'b0}}, prod_p0};
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: accumulator and control registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      done_q  <= (state_d == DONE);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign acc_out = acc_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mult_acc_unit.sv
// Bench for mult_acc_unit: directed runs with literal results plus randomized
// traffic, all compared against an integer-level model every cycle.
module tb_mult_acc_unit;
  localparam int N     = 8;
  localparam int LEN_W = 5;
  localparam int ACC_W = 2*N + LEN_W;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic             ack = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [N-1:0]     a_in = '0;
  logic [N-1:0]     b_in = '0;
  logic             in_ready, done, busy;
  logic [ACC_W-1:0] acc_out;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Model: running sum, pairs still owed, and handshake flags
  longint m_acc  = 0;
  int     m_left = 0;
  bit     m_busy = 1'b0;
  bit     m_done = 1'b0;
  bit     m_rdy  = 1'b0;

  always #5 clk = ~clk;

  mult_acc_unit #(.N(N), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .a_in(a_in), .b_in(b_in), .in_valid(in_valid), .in_ready(in_ready),
    .acc_out(acc_out), .done(done), .ack(ack), .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      m_acc <= 0; m_left <= 0; m_busy <= 1'b0; m_done <= 1'b0; m_rdy <= 1'b0;
    end else if (!m_busy) begin
      if (start) begin
        m_acc  <= 0;
        m_left <= int'(len);
        m_busy <= 1'b1;
        if (len == 0) m_done <= 1'b1;
        else          m_rdy  <= 1'b1;
      end
    end else if (m_rdy) begin
      if (in_valid) begin
        m_acc  <= m_acc + longint'(a_in) * longint'(b_in);
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_rdy  <= 1'b0;
          m_done <= 1'b1;
        end
      end
    end else if (m_done && ack) begin
      m_done <= 1'b0;
      m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_acc", acc_out, m_acc);
      chk("model_busy", busy, m_busy);
      chk("model_done", done, m_done);
      chk("model_in_ready", in_ready, m_rdy);
    end
  end

  task automatic do_start(input int l);
    start = 1'b1;
    len   = LEN_W'(l);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int a, input int b);
    in_valid = 1'b1;
    a_in     = N'(a);
    b_in     = N'(b);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst    = 1'b1;
    chk_en = 1'b1;
    chk("rst_acc", acc_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);

    // basic run
    do_start(3);
    chk("basic_in_ready", in_ready, 1);
    send(2, 3);
    send(4, 5);
    chk("basic_done_early", done, 0);
    send(255, 255);
    chk("basic_done", done, 1);
    chk("basic_acc", acc_out, 65051);
    chk("basic_ready_off", in_ready, 0);
    do_ack();
    chk("basic_ack_done", done, 0);
    chk("basic_ack_busy", busy, 0);
    chk("basic_idle_hold", acc_out, 65051);

    // empty run
    do_start(0);
    chk("empty_done", done, 1);
    chk("empty_acc", acc_out, 0);
    chk("empty_in_ready", in_ready, 0);
    repeat (2) begin
      @(negedge clk);
      chk("empty_in_ready_hold", in_ready, 0);
    end
    do_ack();

    // maximum run
    do_start(31);
    repeat (31) send(255, 255);
    chk("max_done", done, 1);
    chk("max_acc", acc_out, 2015775);
    do_ack();

    // stalls with garbage operands while invalid
    do_start(2);
    send(10, 10);
    repeat (4) begin
      a_in = N'($urandom);
      b_in = N'($urandom);
      chk("stall_busy", busy, 1);
      chk("stall_done", done, 0);
      @(negedge clk);
    end
    send(1, 1);
    chk("stall_done_end", done, 1);
    chk("stall_acc", acc_out, 101);
    do_ack();

    // reset during RUN
    do_start(2);
    send(7, 9);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("abort_acc", acc_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_in_ready", in_ready, 0);
    @(negedge clk);
    chk("abort_stays_idle", busy, 0);
    do_start(2);
    send(3, 4);
    send(5, 6);
    chk("fresh_done", done, 1);
    chk("fresh_acc", acc_out, 42);
    do_ack();

    // DONE handshake corners
    do_start(1);
    send(6, 7);
    repeat (10) begin
      chk("hold_done", done, 1);
      chk("hold_acc", acc_out, 42);
      @(negedge clk);
    end
    start = 1'b1;
    ack   = 1'b1;
    len   = LEN_W'(3);
    @(negedge clk);
    start = 1'b0;
    ack   = 1'b0;
    chk("startack_busy", busy, 0);
    chk("startack_done", done, 0);
    chk("startack_acc", acc_out, 42);
    @(negedge clk);
    chk("startack_no_run", in_ready, 0);

    // randomized traffic including stray start/ack and occasional reset
    repeat (3000) begin
      start    = ($urandom_range(0, 7) == 0);
      len      = ($urandom_range(0, 9) == 0) ? LEN_W'($urandom) : LEN_W'($urandom_range(0, 5));
      in_valid = ($urandom_range(0, 3) != 0);
      a_in     = N'($urandom);
      b_in     = N'($urandom);
      ack      = ($urandom_range(0, 3) == 0);
      rst      = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0; ack = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
